bus_master_controller: RTL and testbench

//  Scenario sequencer for the dual-master system-bus demo. It sits between the

---
 rtl/bus_master_controller.sv | 114 +++++++++++
 tb/tb_bus_master_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_master_controller.sv
// Scenario sequencer for the dual-master bus demo: latches a scenario code on start,
// loads both masters' commands, strobes their enables, then waits for them to finish.
module bus_master_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  state_in,
    input  logic        m1_request,
    input  logic        m2_request,
    output logic        m1_enable,
    output logic        m2_enable,
    output logic        m1_read_en,
    output logic        m2_read_en,
    output logic [7:0]  data_in1,
    output logic [7:0]  data_in2,
    output logic [13:0] addr_in1,
    output logic [13:0] addr_in2
);

    typedef enum logic [1:0] {IDLE, LOAD, ENABLE, WAIT} state_t;

    state_t      state;
    logic [4:0]  scenario;
    logic        use1, use2;

    logic        t_use1, t_use2, t_rd1, t_rd2;
    logic [7:0]  t_data1, t_data2;
    logic [13:0] t_addr1, t_addr2;

    // Fixed scenario table; codes 0 and 11..31 use neither master.
    always_comb begin
        t_use1  = 1'b0;
        t_use2  = 1'b0;
        t_rd1   = 1'b0;
        t_rd2   = 1'b0;
        t_data1 = '0;
        t_data2 = '0;
        t_addr1 = '0;
        t_addr2 = '0;
        case (scenario)
            5'd1:  begin t_use1 = 1'b1; t_addr1 = 14'h0012; t_data1 = 8'hA5; end
            5'd2:  begin t_use1 = 1'b1; t_addr1 = 14'h0012; t_rd1 = 1'b1; end
            5'd3:  begin t_use2 = 1'b1; t_addr2 = 14'h1034; t_data2 = 8'h3C; end
            5'd4:  begin t_use2 = 1'b1; t_addr2 = 14'h1034; t_rd2 = 1'b1; end
            5'd5:  begin t_use1 = 1'b1; t_addr1 = 14'h2056; t_data1 = 8'h5A; end
            5'd6:  begin t_use1 = 1'b1; t_addr1 = 14'h2056; t_rd1 = 1'b1; end
            5'd7:  begin t_use2 = 1'b1; t_addr2 = 14'h0012; t_rd2 = 1'b1; end
            5'd8:  begin
                t_use1 = 1'b1; t_addr1 = 14'h0012; t_data1 = 8'h11;
                t_use2 = 1'b1; t_addr2 = 14'h1034; t_data2 = 8'h22;
            end
            5'd9:  begin
                t_use1 = 1'b1; t_addr1 = 14'h2056; t_data1 = 8'h33;
                t_use2 = 1'b1; t_addr2 = 14'h2056; t_data2 = 8'h44;
            end
            5'd10: begin
                t_use1 = 1'b1; t_addr1 = 14'h0012; t_rd1 = 1'b1;
                t_use2 = 1'b1; t_addr2 = 14'h0012; t_data2 = 8'h55;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            scenario   <= '0;
            use1       <= 1'b0;
            use2       <= 1'b0;
            m1_enable  <= 1'b0;
            m2_enable  <= 1'b0;
            m1_read_en <= 1'b0;
            m2_read_en <= 1'b0;
            data_in1   <= '0;
            data_in2   <= '0;
            addr_in1   <= '0;
            addr_in2   <= '0;
        end else begin
            m1_enable <= 1'b0;
            m2_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scenario <= state_in;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    use1       <= t_use1;
                    use2       <= t_use2;
                    m1_read_en <= t_rd1;
                    m2_read_en <= t_rd2;
                    data_in1   <= t_data1;
                    data_in2   <= t_data2;
                    addr_in1   <= t_addr1;
                    addr_in2   <= t_addr2;
                    state      <= ENABLE;
                end
                ENABLE: begin
                    m1_enable <= use1;
                    m2_enable <= use2;
                    state     <= WAIT;
                end
                WAIT: begin
                    // Busy lines of masters outside the scenario are ignored.
                    if (!(use1 && m1_request) && !(use2 && m2_request))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_controller.sv
// Self-checking bench for bus_master_controller: scenario table vectors, directed
// multi-cycle sequences and randomized transactions against a timeline model.
module tb_bus_master_controller;

    logic        clk = 1'b0;
    logic        reset, start, m1_request, m2_request;
    logic [4:0]  state_in;
    logic        m1_enable, m2_enable, m1_read_en, m2_read_en;
    logic [7:0]  data_in1, data_in2;
    logic [13:0] addr_in1, addr_in2;

    int checks   = 0;
    int failures = 0;

    bus_master_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .state_in   (state_in),
        .m1_request (m1_request),
        .m2_request (m2_request),
        .m1_enable  (m1_enable),
        .m2_enable  (m2_enable),
        .m1_read_en (m1_read_en),
        .m2_read_en (m2_read_en),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .addr_in1   (addr_in1),
        .addr_in2   (addr_in2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  code;
        logic        u1, u2, r1, r2;
        logic [7:0]  d1, d2;
        logic [13:0] a1, a2;
    } vec_t;

    vec_t vecs[14];
    vec_t cur;

    function automatic vec_t cmd_of(input logic [4:0] code);
        vec_t v;
        v = '0;
        v.code = code;
        foreach (vecs[i]) if (vecs[i].code == code) v = vecs[i];
        return v;
    endfunction

    function automatic logic [47:0] pack(input vec_t v, input logic e1, input logic e2);
        return {e1, e2, v.r1, v.r2, v.d1, v.d2, v.a1, v.a2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] exp);
        logic [47:0] act;
        act = {m1_enable, m2_enable, m1_read_en, m2_read_en, data_in1, data_in2, addr_in1, addr_in2};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Start held high at the acceptance edge; exit edge is 3 + longest busy time of used masters.
    task automatic run_txn(input logic [4:0] code, input int d1, input int d2);
        vec_t v;
        int   dmax;
        v = cmd_of(code);
        dmax = 0;
        if (v.u1 && d1 > dmax) dmax = d1;
        if (v.u2 && d2 > dmax) dmax = d2;
        start = 1'b1;
        state_in = code;
        m1_request = 1'($urandom);
        m2_request = 1'($urandom);
        tick();
        chk("accept", pack(cur, 1'b0, 1'b0));
        cur = v;
        for (int k = 1; k <= 3 + dmax; k++) begin
            start = 1'($urandom);
            state_in = 5'($urandom);
            m1_request = (v.u1 && k >= 3) ? (k - 3 < d1) : 1'($urandom);
            m2_request = (v.u2 && k >= 3) ? (k - 3 < d2) : 1'($urandom);
            tick();
            chk(k == 1 ? "load" : (k == 2 ? "enable" : "wait"),
                pack(v, (k == 2) && v.u1, (k == 2) && v.u2));
        end
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            state_in = 5'($urandom);
            m1_request = 1'($urandom);
            m2_request = 1'($urandom);
            tick();
            chk("idle_hold", pack(cur, 1'b0, 1'b0));
        end
    endtask

    initial begin
        vecs[0]  = '{5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 14'h0000, 14'h0000};
        vecs[1]  = '{5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 14'h0012, 14'h0000};
        vecs[2]  = '{5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 14'h0012, 14'h0000};
        vecs[3]  = '{5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 14'h0000, 14'h1034};
        vecs[4]  = '{5'd4,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 14'h0000, 14'h1034};
        vecs[5]  = '{5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 14'h2056, 14'h0000};
        vecs[6]  = '{5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 14'h2056, 14'h0000};
        vecs[7]  = '{5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 14'h0000, 14'h0012};
        vecs[8]  = '{5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 14'h0012, 14'h1034};
        vecs[9]  = '{5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44, 14'h2056, 14'h2056};
        vecs[10] = '{5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 14'h0012, 14'h0012};
        vecs[11] = '{5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 14'h0000, 14'h0000};
        vecs[12] = '{5'd20, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 14'h0000, 14'h0000};
        vecs[13] = '{5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 14'h0000, 14'h0000};
        cur = '0;

        reset = 1'b0;
        start = 1'b1;
        state_in = 5'd1;
        m1_request = 1'b0;
        m2_request = 1'b0;
        tick();
        chk("reset_cycle1", '0);
        tick();
        chk("reset_cycle2", '0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("idle_after_reset", '0);

        run_txn(5'd1, 5, 0);
        idle_hold(2);
        run_txn(5'd2, 2, 0);
        idle_hold(1);
        run_txn(5'd8, 1, 4);
        run_txn(5'd8, 4, 1);
        idle_hold(1);
        run_txn(5'd20, 3, 3);
        run_txn(5'd3, 0, 2);
        idle_hold(2);

        foreach (vecs[i]) begin
            run_txn(vecs[i].code, $urandom_range(0, 3), $urandom_range(0, 3));
            idle_hold(1);
        end

        start = 1'b1;
        state_in = 5'd9;
        m1_request = 1'b0;
        m2_request = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("s9_enable", pack(cmd_of(5'd9), 1'b1, 1'b1));
        m1_request = 1'b1;
        m2_request = 1'b1;
        tick();
        tick();
        chk("s9_wait_hold", pack(cmd_of(5'd9), 1'b0, 1'b0));
        reset = 1'b0;
        tick();
        chk("reset_in_wait", '0);
        reset = 1'b1;
        m1_request = 1'b0;
        m2_request = 1'b0;
        tick();
        chk("idle_after_wait_reset", '0);
        cur = '0;
        run_txn(5'd2, 1, 0);
        idle_hold(1);

        for (int t = 0; t < 60; t++) begin
            logic [4:0] code;
            code = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 10)) : 5'($urandom);
            run_txn(code, $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) idle_hold($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
